// File: rtl/lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : lock_supervisor
// Purpose  : Supervises a keypad lock. It edge-detects the user buttons,
//            locks the keypad out after repeated wrong codes, escalates to a
//            sticky alarm after repeated lockouts, and relocks an idle OPEN
//            lock by issuing an enter pulse.
// Revision : 1.0 - initial release
// ============================================================================
module lock_supervisor #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int RELOCK_CYCLES  = 5000,
  parameter int ALARM_LOCKOUTS = 3
) (
  input  logic       clk,
  input  logic       hard_rst,
  input  logic       enter_in,
  input  logic       clr_in,
  input  logic       rst_in,
  input  logic [9:0] keypad_in,
  input  logic       unlock,
  input  logic       incorrect,
  output logic       enter_out,
  output logic       clr_out,
  output logic       rst_out,
  output logic [9:0] keypad_out,
  output logic       lockout,
  output logic       alarm,
  output logic [3:0] fail_count
);

  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES);
  localparam int IDLE_W = $clog2(RELOCK_CYCLES);
  localparam int LCNT_W = $clog2(ALARM_LOCKOUTS + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RELOCK_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(ALARM_LOCKOUTS);
  localparam logic [3:0]        FAIL_MAX  = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          fail_q, fail_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                prog_q, prog_d;
  logic                enter_prev_q, clr_prev_q, rst_prev_q;
  logic                enter_out_q, enter_out_d;
  logic                clr_out_q, clr_out_d;
  logic                rst_out_q, rst_out_d;

  logic                pass;
  logic                enter_rise, clr_rise, rst_rise;
  logic                activity;
  logic [3:0]          fail_inc;
  logic [LCNT_W-1:0]   lcnt_inc;

  // Next-state, counter and pulse logic; commands only pass in ARMED/OPEN.
  always_comb begin
    pass       = (state_q == ST_ARMED) || (state_q == ST_OPEN);
    enter_rise = enter_in & ~enter_prev_q;
    clr_rise   = clr_in & ~clr_prev_q;
    rst_rise   = rst_in & ~rst_prev_q;
    activity   = (|keypad_in) | enter_in | clr_in | rst_in;
    fail_inc   = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    lcnt_inc   = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + 1'b1;

    state_d     = state_q;
    fail_d      = fail_q;
    lcnt_d      = lcnt_q;
    timer_d     = timer_q;
    idle_d      = idle_q;
    prog_d      = prog_q;
    enter_out_d = pass & enter_rise;
    clr_out_d   = pass & clr_rise;
    rst_out_d   = pass & rst_rise;

    case (state_q)
      ST_ARMED: begin
        prog_d  = 1'b0;
        idle_d  = '0;
        timer_d = '0;
        if (unlock) begin
          // A correct code beats a simultaneous failure report.
          state_d = ST_OPEN;
          fail_d  = 4'd0;
          lcnt_d  = '0;
        end else if (incorrect) begin
          if (fail_inc == FAIL_MAX) begin
            state_d   = ST_LOCKOUT;
            fail_d    = 4'd0;
            lcnt_d    = lcnt_inc;
            clr_out_d = 1'b1;  // wipe the partial try on the first lockout cycle
          end else begin
            fail_d = fail_inc;
          end
        end
      end
      ST_OPEN: begin
        if (!unlock) begin
          state_d = ST_ARMED;
          idle_d  = '0;
          prog_d  = 1'b0;
        end else begin
          if (rst_rise) prog_d = 1'b1;
          if (activity) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            // While reprogramming the counter parks here instead of committing.
            if (!prog_q) begin
              enter_out_d = 1'b1;
              idle_d      = '0;
            end
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          state_d = (lcnt_q == LCNT_MAX) ? ST_ALARM : ST_ARMED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase
  end

  // State and counter registers; hard_rst overrides everything.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q      <= ST_ARMED;
      fail_q       <= 4'd0;
      lcnt_q       <= '0;
      timer_q      <= '0;
      idle_q       <= '0;
      prog_q       <= 1'b0;
      enter_prev_q <= 1'b0;
      clr_prev_q   <= 1'b0;
      rst_prev_q   <= 1'b0;
      enter_out_q  <= 1'b0;
      clr_out_q    <= 1'b0;
      rst_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_q       <= fail_d;
      lcnt_q       <= lcnt_d;
      timer_q      <= timer_d;
      idle_q       <= idle_d;
      prog_q       <= prog_d;
      enter_prev_q <= enter_in;
      clr_prev_q   <= clr_in;
      rst_prev_q   <= rst_in;
      enter_out_q  <= enter_out_d;
      clr_out_q    <= clr_out_d;
      rst_out_q    <= rst_out_d;
    end
  end

  assign enter_out  = enter_out_q;
  assign clr_out    = clr_out_q;
  assign rst_out    = rst_out_q;
  assign keypad_out = pass ? keypad_in : 10'd0;
  assign lockout    = (state_q == ST_LOCKOUT);
  assign alarm      = (state_q == ST_ALARM);
  assign fail_count = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_supervisor
// Purpose  : Self-checking bench for lock_supervisor with small parameters
//            (MAX_FAILS=3, LOCKOUT_CYCLES=8, RELOCK_CYCLES=16,
//            ALARM_LOCKOUTS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_supervisor;

  logic       clk = 1'b0;
  logic       hard_rst, enter_in, clr_in, rst_in, unlock, incorrect;
  logic [9:0] keypad_in, keypad_out;
  logic       enter_out, clr_out, rst_out, lockout, alarm;
  logic [3:0] fail_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lock_supervisor #(
    .MAX_FAILS(3), .LOCKOUT_CYCLES(8), .RELOCK_CYCLES(16), .ALARM_LOCKOUTS(2)
  ) dut (
    .clk(clk), .hard_rst(hard_rst), .enter_in(enter_in), .clr_in(clr_in),
    .rst_in(rst_in), .keypad_in(keypad_in), .unlock(unlock),
    .incorrect(incorrect), .enter_out(enter_out), .clr_out(clr_out),
    .rst_out(rst_out), .keypad_out(keypad_out), .lockout(lockout),
    .alarm(alarm), .fail_count(fail_count)
  );

  typedef struct packed {
    logic hr, en, cl, rs; logic [9:0] kp; logic ul, inc;
  } stim_t;
  typedef struct packed {
    logic eo, co, ro; logic [9:0] ko; logic lo, al; logic [3:0] fc;
  } exp_t;
  typedef struct packed { stim_t s; exp_t e; } vec_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input stim_t s);
    hard_rst = s.hr; enter_in = s.en; clr_in = s.cl; rst_in = s.rs;
    keypad_in = s.kp; unlock = s.ul; incorrect = s.inc;
  endtask

  task automatic mk(input int hr, input int en, input int cl, input int rs,
                    input int kp, input int ul, input int inc,
                    input int eo, input int co, input int ro, input int ko,
                    input int lo, input int al, input int fc);
    vec_t v;
    v.s = {1'(hr), 1'(en), 1'(cl), 1'(rs), 10'(kp), 1'(ul), 1'(inc)};
    v.e = {1'(eo), 1'(co), 1'(ro), 10'(ko), 1'(lo), 1'(al), 4'(fc)};
    vecs.push_back(v);
  endtask

  task automatic quiet_inputs();
    enter_in = 1'b0; clr_in = 1'b0; rst_in = 1'b0; keypad_in = 10'd0;
    incorrect = 1'b0; hard_rst = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    unlock = 1'b0;
    hard_rst = 1'b1;
    cyc();
    hard_rst = 1'b0;
  endtask

  // n idle OPEN cycles, each required to show no enter pulse
  task automatic quiet(input int n, input string tag);
    quiet_inputs();
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, enter_out, 0);
    end
  endtask

  task automatic fail_three();
    for (int i = 0; i < 3; i++) begin
      incorrect = 1'b1;
      cyc();
    end
    incorrect = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp_t act;
    exp_t ex;
    quiet_inputs();
    unlock = 1'b0;

    // hr en cl rs kp ul inc | eo co ro ko lo al fc
    mk(1,1,0,0,10'h000,0,1, 0,0,0,10'h000,0,0,0);  // reset beats inputs
    mk(0,0,0,0,10'h001,0,0, 0,0,0,10'h001,0,0,0);  // keypad passes in ARMED
    mk(0,1,0,0,10'h000,0,0, 1,0,0,10'h000,0,0,0);  // enter edge
    mk(0,1,0,0,10'h000,0,0, 0,0,0,10'h000,0,0,0);  // held: no second pulse
    mk(0,0,1,0,10'h000,0,0, 0,1,0,10'h000,0,0,0);  // clr edge
    mk(0,0,0,1,10'h000,0,0, 0,0,1,10'h000,0,0,0);  // rst edge
    mk(0,0,0,0,10'h000,0,1, 0,0,0,10'h000,0,0,1);  // fail 1
    mk(0,0,0,0,10'h000,0,0, 0,0,0,10'h000,0,0,1);
    mk(0,0,0,0,10'h004,0,1, 0,0,0,10'h004,0,0,2);  // fail 2
    mk(0,0,0,0,10'h004,0,1, 0,1,0,10'h000,1,0,0);  // third -> LOCKOUT, clr pulse
    mk(0,1,0,0,10'h008,0,0, 0,0,0,10'h000,1,0,0);  // enter suppressed
    for (int i = 0; i < 6; i++)
      mk(0,0,0,0,10'h000,0,0, 0,0,0,10'h000,1,0,0);
    mk(0,0,0,0,10'h010,0,0, 0,0,0,10'h010,0,0,0);  // back to ARMED after 8
    mk(0,0,0,0,10'h000,0,1, 0,0,0,10'h000,0,0,1);
    mk(0,0,0,0,10'h000,1,1, 0,0,0,10'h000,0,0,0);  // unlock wins
    mk(0,0,0,0,10'h000,1,1, 0,0,0,10'h000,0,0,0);  // OPEN ignores incorrect
    mk(0,0,0,0,10'h000,0,0, 0,0,0,10'h000,0,0,0);  // unlock falls -> ARMED
    mk(0,0,0,0,10'h000,0,1, 0,0,0,10'h000,0,0,1);  // counting again

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s);
      sbq.push_back(vecs[i].e);
      cyc();
      ex  = sbq.pop_front();
      act = {enter_out, clr_out, rst_out, keypad_out, lockout, alarm, fail_count};
      chk($sformatf("vec%0d", i), 32'(act), 32'(ex));
    end

    // Two lockouts with no unlock escalate to a sticky alarm
    do_reset();
    fail_three();
    chk("lo1_entry", lockout, 1);
    keypad_in = 10'h040;
    repeat (7) cyc();
    chk("lo1_last", lockout, 1);
    chk("lo1_kp_gated", keypad_out, 0);
    keypad_in = 10'h000;
    cyc();
    chk("lo1_exit", lockout, 0);
    fail_three();
    chk("lo2_entry", lockout, 1);
    repeat (7) cyc();
    chk("lo2_last", lockout, 1);
    cyc();
    chk("alarm_on", alarm, 1);
    chk("alarm_lo", lockout, 0);
    for (int i = 0; i < 100; i++) begin
      enter_in  = i[0];
      keypad_in = 10'h080;
      unlock    = i[1];
      cyc();
      chk("alarm_hold", alarm, 1);
      chk("alarm_enter", enter_out, 0);
      chk("alarm_kp", keypad_out, 0);
    end
    quiet_inputs();
    unlock = 1'b0;
    hard_rst = 1'b1; incorrect = 1'b1; keypad_in = 10'h100;
    cyc();
    hard_rst = 1'b0; incorrect = 1'b0;
    chk("alarm_rst_al", alarm, 0);
    chk("alarm_rst_fc", fail_count, 0);
    chk("alarm_rst_kp", keypad_out, 10'h100);

    // hard_rst in the middle of a lockout
    do_reset();
    fail_three();
    repeat (3) cyc();
    chk("mid_lo", lockout, 1);
    hard_rst = 1'b1; keypad_in = 10'h020;
    cyc();
    hard_rst = 1'b0;
    chk("mid_rst_lo", lockout, 0);
    chk("mid_rst_kp", keypad_out, 10'h020);
    chk("mid_rst_fc", fail_count, 0);
    chk("mid_rst_co", clr_out, 0);
    keypad_in = 10'h000;
    incorrect = 1'b1;
    cyc();
    incorrect = 1'b0;
    chk("mid_rst_armed", fail_count, 1);

    // Auto-relock timing in OPEN
    do_reset();
    unlock = 1'b1;
    cyc();
    quiet(15, "relock_pre");
    cyc();
    chk("relock_pulse", enter_out, 1);
    quiet(14, "relock_after");
    keypad_in = 10'h001;   // key in the 15th idle cycle
    cyc();
    chk("defer_key", enter_out, 0);
    quiet(15, "defer_wait");
    cyc();
    chk("defer_pulse", enter_out, 1);
    quiet(15, "expiry_pre");
    keypad_in = 10'h002;   // activity exactly at expiry
    cyc();
    chk("expiry_key", enter_out, 0);
    quiet(15, "expiry_wait");
    cyc();
    chk("expiry_pulse", enter_out, 1);
    quiet(15, "coinc_pre");
    enter_in = 1'b1;       // user enter at expiry
    cyc();
    chk("coinc_pulse", enter_out, 1);
    enter_in = 1'b0;
    cyc();
    chk("coinc_single", enter_out, 0);
    quiet(14, "coinc_wait");
    cyc();
    chk("coinc_next", enter_out, 1);

    // Reprogramming disables relock; unlock falling ends it
    quiet_inputs();
    rst_in = 1'b1;
    cyc();
    chk("prog_rst_out", rst_out, 1);
    quiet(40, "prog_idle");
    unlock = 1'b0;
    cyc();
    incorrect = 1'b1;
    cyc();
    incorrect = 1'b0;
    chk("prog_armed", fail_count, 1);
    unlock = 1'b1;
    cyc();
    quiet(15, "prog_clear_pre");
    cyc();
    chk("prog_cleared", enter_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
